dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (port p_) and the program/data loader (port l_).
- Fixed priority to the pipeline, with an anti-starvation counter for the loader.
- Drives the data memory strobes and checks address range and alignment.
- Returns read data through registered, one-cycle-latency response ports.
- Sits between the MEM stage and the data memory, and produces the MEM-stage stall signal.

Parameters:
- BASE_ADDR, 32'h10001000, byte address of data memory word 0.
- DEPTH, 64, number of 32-bit words in the data memory.
- STARVE_LIMIT, 4, cycles a loader request may wait before it overrides pipeline priority (range 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- p_req  in  1  pipeline access request; level signal, held until granted.
- p_we  in  1  pipeline write (1) or read (0).
- p_addr  in  32  pipeline byte address.
- p_wdata  in  32  pipeline write data.
- p_gnt  out  1  pipeline request accepted this cycle (combinational).
- p_rvalid  out  1  pipeline response valid; one-cycle pulse.
- p_rdata  out  32  pipeline read data; valid with p_rvalid.
- p_err  out  1  pipeline access error; valid with p_rvalid.
- l_req, l_we, l_addr, l_wdata  in  1/1/32/32  loader request; same semantics as the p_ inputs.
- l_gnt, l_rvalid, l_rdata, l_err  out  1/1/32/1  loader response; same semantics as the p_ outputs.
- mem_addr  out  32  byte address to data memory.
- mem_wdata  out  32  write data to data memory.
- mem_read  out  1  data memory read strobe.
- mem_write  out  1  data memory write strobe; memory writes on the rising edge.
- mem_rdata  in  32  data memory read data; combinational from mem_addr.
- stall  out  1  p_req & ~p_gnt; freezes the pipeline.

Behaviour:
- Reset (rst low, asynchronous):
  - starve_cnt=0; p_rvalid, l_rvalid, p_err, l_err = 0; p_rdata, l_rdata = 0.
  - While rst is low, p_gnt, l_gnt, mem_read, mem_write and stall are forced to 0, and mem_addr, mem_wdata = 0.
- Arbitration (combinational, each cycle):
  - If only one requester is active, it wins.
  - If both are active, the pipeline wins unless starve_cnt == STARVE_LIMIT, in which case the loader wins.
  - At most one gnt is high per cycle.
  - The loser's request must stay stable; the loser gets no strobe.
- starve_cnt (registered):
  - Increments when l_req & ~l_gnt, saturating at STARVE_LIMIT.
  - Clears when l_gnt is high or l_req is low.
- Access check on the winner's address:
  - Legal only if addr[1:0]==0 and BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH.
  - Compare using 33-bit unsigned arithmetic so the upper bound does not wrap.
- Legal grant:
  - mem_addr and mem_wdata take the winner's values.
  - Write: mem_write=1, mem_read=0. Read: mem_read=1, mem_write=0.
  - mem_read and mem_write are never both 1.
- Illegal grant:
  - gnt is still asserted (the request is consumed) and no strobe is driven.
  - The response is err=1 with rdata=0.
- Response (registered, issued at the edge that ends the grant cycle):
  - The granted port gets rvalid=1 for exactly one cycle.
  - Read: rdata = captured mem_rdata.
  - Write: rdata = 0, err = 0 for a legal write.
  - The non-granted port has rvalid=0 and keeps its rdata.
  - err clears when rvalid falls.
- Throughput: one access per cycle, back-to-back. A requester holding req high across consecutive cycles is granted each cycle it wins.
- Read-after-write to the same address in consecutive cycles returns the new data, because the memory write has committed by the next cycle.
- Reset mid-operation: a pending response is discarded (rvalid cleared), and no partial write is allowed after rst falls.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with p_req=1 -> p_gnt=0, mem_read=0, stall=0, p_rvalid=0. Release -> p_gnt=1 in the same cycle.
2. Pipeline write then read:
   - p_we=1, p_addr=0x1000101C, p_wdata=0x00ABCDEF -> mem_write=1 for one cycle, p_rvalid=1 and p_err=0 next cycle.
   - Then read 0x1000101C -> p_rdata=0x00ABCDEF one cycle after grant.
3. Contention and starvation (STARVE_LIMIT=4): hold p_req and l_req high continuously.
   - p_gnt is high for 4 cycles with l_gnt low.
   - Cycle 5: l_gnt=1, p_gnt=0, stall=1.
   - Cycle 6: p_gnt resumes, starve_cnt=0.
4. Errors:
   - Read 0x10001006 (misaligned) -> p_gnt=1, no strobe, p_err=1, p_rdata=0.
   - Loader read 0x10001100 (= BASE+4*64, out of range) -> l_err=1.
   - Loader read 0x100010FC -> l_err=0.
5. Back-to-back loader writes to 0x10001000, 0x10001004, 0x10001008 (3 cycles) -> 3 consecutive l_rvalid pulses. A subsequent pipeline read of 0x10001004 returns the loader's value.
6. Assert rst low on the cycle after a read grant -> p_rvalid drops immediately, and no mem strobe occurs while rst is low.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: pipeline MEM stage has
// priority, the loader gets a guaranteed slot after STARVE_LIMIT lost cycles.
module dmem_arbiter #(
    parameter logic [31:0] BASE_ADDR    = 32'h10001000,
    parameter int          DEPTH        = 64,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic        p_gnt,
    output logic        p_rvalid,
    output logic [31:0] p_rdata,
    output logic        p_err,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    output logic        l_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        stall
);

    localparam logic [3:0]  LIMIT   = 4'(STARVE_LIMIT);
    // 33-bit bounds so BASE_ADDR + 4*DEPTH cannot wrap past 2^32
    localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] ADDR_HI = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    logic [3:0]  starve_cnt_reg;
    logic [3:0]  starve_cnt_next;
    logic        starved;
    logic        any_gnt;
    logic        acc_we;
    logic        acc_legal;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [32:0] addr_ext;
    logic [31:0] resp_data;

    always_comb begin
        starved   = (starve_cnt_reg == LIMIT);
        // rst gates every grant so nothing reaches the memory while in reset
        p_gnt     = rst & p_req & (~l_req | ~starved);
        l_gnt     = rst & l_req & (~p_req | starved);
        any_gnt   = p_gnt | l_gnt;

        acc_we    = l_gnt ? l_we    : p_we;
        acc_addr  = l_gnt ? l_addr  : p_addr;
        acc_wdata = l_gnt ? l_wdata : p_wdata;
        addr_ext  = {1'b0, acc_addr};
        acc_legal = (acc_addr[1:0] == 2'b00) && (addr_ext >= ADDR_LO) && (addr_ext < ADDR_HI);

        mem_addr  = rst ? acc_addr  : 32'h0;
        mem_wdata = rst ? acc_wdata : 32'h0;
        mem_read  = any_gnt & acc_legal & ~acc_we;
        mem_write = any_gnt & acc_legal & acc_we;
        stall     = rst & p_req & ~p_gnt;

        resp_data = mem_read ? mem_rdata : 32'h0;

        starve_cnt_next = 4'd0;
        if (l_req && !l_gnt) begin
            starve_cnt_next = starved ? starve_cnt_reg : starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_reg <= 4'd0;
            p_rvalid       <= 1'b0;
            p_err          <= 1'b0;
            p_rdata        <= 32'h0;
            l_rvalid       <= 1'b0;
            l_err          <= 1'b0;
            l_rdata        <= 32'h0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            p_rvalid       <= p_gnt;
            p_err          <= p_gnt & ~acc_legal;
            l_rvalid       <= l_gnt;
            l_err          <= l_gnt & ~acc_legal;
            // the losing port keeps its last read data
            if (p_gnt) begin
                p_rdata <= resp_data;
            end
            if (l_gnt) begin
                l_rdata <= resp_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_req, p_we, l_req, l_we;
    logic [31:0] p_addr, p_wdata, l_addr, l_wdata;
    logic        p_gnt, p_rvalid, p_err, l_gnt, l_rvalid, l_err;
    logic [31:0] p_rdata, l_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, stall;

    logic [31:0] ram [0:63];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) ram[mem_addr[7:2]] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr[7:2]];

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata), .p_err(p_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .stall(stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic p_set(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        p_req = req; p_we = we; p_addr = addr; p_wdata = wd;
    endtask

    task automatic l_set(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        l_req = req; l_we = we; l_addr = addr; l_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'hA5000000 | i;
        rst = 1'b0;
        p_set(1'b1, 1'b0, 32'h10001000, 32'h0);
        l_set(1'b0, 1'b0, 32'h0, 32'h0);

        // 1: reset holds everything quiet, release grants immediately
        $display("step 1: reset");
        tick(); tick();
        chk("rst_p_gnt", 32'(p_gnt), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_p_rvalid", 32'(p_rvalid), 32'd0);
        chk("rst_p_rdata", p_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b1;
        #1;
        chk("rel_p_gnt", 32'(p_gnt), 32'd1);
        chk("rel_mem_read", 32'(mem_read), 32'd1);
        tick();
        chk("rel_p_rvalid", 32'(p_rvalid), 32'd1);
        chk("rel_p_rdata", p_rdata, 32'hA5000000);

        // 2: pipeline write then read back
        $display("step 2: pipeline write/read");
        p_set(1'b1, 1'b1, 32'h1000101C, 32'h00ABCDEF);
        #1;
        chk("wr_mem_write", 32'(mem_write), 32'd1);
        chk("wr_mem_read", 32'(mem_read), 32'd0);
        chk("wr_mem_addr", mem_addr, 32'h1000101C);
        chk("wr_mem_wdata", mem_wdata, 32'h00ABCDEF);
        tick();
        chk("wr_p_rvalid", 32'(p_rvalid), 32'd1);
        chk("wr_p_err", 32'(p_err), 32'd0);
        chk("wr_p_rdata", p_rdata, 32'h0);
        p_set(1'b1, 1'b0, 32'h1000101C, 32'h0);
        #1;
        chk("rd_mem_read", 32'(mem_read), 32'd1);
        chk("rd_mem_write", 32'(mem_write), 32'd0);
        tick();
        chk("rd_p_rdata", p_rdata, 32'h00ABCDEF);
        p_set(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("idle_p_rvalid", 32'(p_rvalid), 32'd0);

        // 3: contention, loader wins every fifth cycle
        $display("step 3: contention");
        p_set(1'b1, 1'b0, 32'h10001000, 32'h0);
        l_set(1'b1, 1'b0, 32'h10001004, 32'h0);
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < 4; k++) begin
                #1;
                chk("cont_p_gnt", 32'(p_gnt), 32'd1);
                chk("cont_l_gnt", 32'(l_gnt), 32'd0);
                tick();
            end
            #1;
            chk("starve_l_gnt", 32'(l_gnt), 32'd1);
            chk("starve_p_gnt", 32'(p_gnt), 32'd0);
            chk("starve_stall", 32'(stall), 32'd1);
            tick();
            chk("starve_l_rvalid", 32'(l_rvalid), 32'd1);
            chk("starve_l_rdata", l_rdata, 32'hA5000001);
            chk("starve_p_rvalid", 32'(p_rvalid), 32'd0);
            chk("starve_p_rdata_kept", p_rdata, 32'hA5000000);
        end
        p_set(1'b0, 1'b0, 32'h0, 32'h0);
        l_set(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // 4: address errors and range boundaries
        $display("step 4: errors");
        p_set(1'b1, 1'b0, 32'h10001006, 32'h0);
        #1;
        chk("mis_p_gnt", 32'(p_gnt), 32'd1);
        chk("mis_strobe", 32'({mem_read, mem_write}), 32'd0);
        tick();
        chk("mis_p_rvalid", 32'(p_rvalid), 32'd1);
        chk("mis_p_err", 32'(p_err), 32'd1);
        chk("mis_p_rdata", p_rdata, 32'h0);
        p_set(1'b0, 1'b0, 32'h0, 32'h0);
        l_set(1'b1, 1'b0, 32'h10001100, 32'h0);
        #1;
        chk("hi_l_gnt", 32'(l_gnt), 32'd1);
        chk("hi_strobe", 32'({mem_read, mem_write}), 32'd0);
        tick();
        chk("hi_l_err", 32'(l_err), 32'd1);
        chk("hi_l_rdata", l_rdata, 32'h0);
        chk("p_err_cleared", 32'(p_err), 32'd0);
        l_set(1'b1, 1'b0, 32'h100010FC, 32'h0);
        #1;
        chk("top_mem_read", 32'(mem_read), 32'd1);
        tick();
        chk("top_l_err", 32'(l_err), 32'd0);
        chk("top_l_rdata", l_rdata, 32'hA500003F);
        l_set(1'b1, 1'b0, 32'h10000FFC, 32'h0);
        tick();
        chk("lo_l_err", 32'(l_err), 32'd1);

        // 5: back-to-back loader writes, pipeline reads one back
        $display("step 5: loader burst");
        for (int k = 0; k < 3; k++) begin
            l_set(1'b1, 1'b1, 32'h10001000 + 32'(4 * k), 32'h11111111 * (k + 1));
            #1;
            chk("burst_mem_write", 32'(mem_write), 32'd1);
            tick();
            chk("burst_l_rvalid", 32'(l_rvalid), 32'd1);
            chk("burst_l_err", 32'(l_err), 32'd0);
        end
        l_set(1'b0, 1'b0, 32'h0, 32'h0);
        p_set(1'b1, 1'b0, 32'h10001004, 32'h0);
        tick();
        chk("burst_l_rvalid_end", 32'(l_rvalid), 32'd0);
        chk("burst_p_rdata", p_rdata, 32'h22222222);

        // 6: reset right after a read grant
        $display("step 6: reset mid-operation");
        p_set(1'b1, 1'b0, 32'h10001008, 32'h0);
        tick();
        chk("mid_p_rvalid", 32'(p_rvalid), 32'd1);
        chk("mid_p_rdata", p_rdata, 32'h33333333);
        p_set(1'b1, 1'b1, 32'h1000100C, 32'hDEADBEEF);
        rst = 1'b0;
        #1;
        chk("mid_rst_p_rvalid", 32'(p_rvalid), 32'd0);
        chk("mid_rst_strobe", 32'({mem_read, mem_write}), 32'd0);
        chk("mid_rst_p_gnt", 32'(p_gnt), 32'd0);
        tick();
        chk("mid_rst_strobe2", 32'({mem_read, mem_write}), 32'd0);
        rst = 1'b1;
        p_set(1'b1, 1'b0, 32'h1000100C, 32'h0);
        tick();
        chk("mid_no_write", p_rdata, 32'hA5000003);
        p_set(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
